ethernet_header_strip: RTL and testbench
========================================

ETHERNET_HEADER_STRIP -- requirements
Module: ethernet_header_strip

Interface
REQ-001 Parameter: DATA_WIDTH, default 512, AXI-Stream data width in bits; SHALL be a multiple of 8 and at least 128.
REQ-002 Parameter: KEEP_WIDTH, default DATA_WIDTH/8, tkeep width; SHALL be derived, not overridden.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be, in order:
- s00_axis_aclk  in  1  clock
- s00_axis_aresetn  in  1  async active-low reset
- s00_axis_tvalid/tdata/tkeep/tlast/tuser  in  1/DATA_WIDTH/KEEP_WIDTH/1/2  upstream frame, Ethernet header first
- s00_axis_tready  out  1  upstream ready
- m00_axis_tvalid/tdata/tkeep/tlast/tuser  out  1/DATA_WIDTH/KEEP_WIDTH/1/2  payload, header removed
- m00_axis_tready  in  1  downstream ready
- local_mac_addr_in  in  48  station MAC, MSB = first wire byte
- promisc_in  in  1  accept all destinations
- hdr_valid  out  1  one-cycle pulse, header fields updated
- hdr_dst_mac, hdr_src_mac  out  48 each  parsed MACs, MSB = first wire byte
- hdr_eth_type  out  16  parsed EtherType, MSB = wire byte 12
- drop_count  out  32  frames discarded

Function
REQ-005 Byte order: tdata byte i = bits [8i+7:8i] and is wire byte i; header = bytes 0-13 of the first beat (dst 0-5, src 6-11, type 12-13).
REQ-006 Output byte j of output beat k SHALL equal input byte j+14 of input beat k for j<50 (scaled to KEEP_WIDTH-14) and input byte j-50 of input beat k+1 otherwise.
REQ-007 Transfers occur only when tvalid && tready are both high; all output fields SHALL stay stable while m00_axis_tvalid=1 && m00_axis_tready=0.
REQ-008 The block SHALL hold one pending input beat and one output register; s00_axis_tready = (!m00_axis_tvalid || m00_axis_tready) in IDLE/STREAM, 1 in DROP, 0 in TAIL and in reset.
REQ-009 States: IDLE (await first beat), STREAM (beat pending), TAIL (emit final residue), DROP (discard to tlast).
REQ-010 IDLE, first beat accepted: latch header fields, pulse hdr_valid next cycle; accept if promisc_in, dst==local_mac_addr_in, or dst==48'hFFFF_FFFF_FFFF.
REQ-011 IDLE, accepted and not tlast: store beat as pending, go STREAM; no output produced.
REQ-012 IDLE, rejected and not tlast: go DROP; rejected and tlast: stay IDLE; each rejected frame increments drop_count once.
REQ-013 Runt: first beat with tlast and popcount(tkeep)<=14 SHALL produce no output, increment drop_count, stay IDLE.
REQ-014 Single beat, tlast, popcount(tkeep)=c>14, accepted: emit one beat, tkeep = low (c-14) bits set, tlast=1, stay IDLE.
REQ-015 STREAM, beat accepted, not tlast: emit pending+new combination (tkeep all ones, tlast=0), new beat becomes pending.
REQ-016 STREAM, tlast with c<=14 valid bytes: emit combined beat, tkeep = low (KEEP_WIDTH-14+c) bits, tlast=1, go IDLE.
REQ-017 STREAM, tlast with c>14: emit combined beat with tkeep all ones, tlast=0; go TAIL; TAIL emits residue (c-14 bytes, upper bytes zero, tlast=1) when output register frees, then IDLE.
REQ-018 m00_axis_tuser SHALL equal s00_axis_tuser of the most recently accepted input beat at emission; TAIL uses the last beat's tuser.
REQ-019 Input tkeep SHALL be treated as contiguous from bit 0; non-contiguous tkeep is undefined.
REQ-020 Throughput: one output beat per cycle with no bubbles in STREAM when m00_axis_tready=1; latency accepted beat k+1 to output beat k valid = 1 cycle.
REQ-021 DROP: accept and discard every beat, emit nothing, return to IDLE after the tlast beat.
REQ-022 drop_count SHALL saturate at 32'hFFFF_FFFF.
REQ-023 hdr_* fields SHALL hold until the next first beat; hdr_valid pulses for runts and rejected frames too.

Reset
REQ-024 On s00_axis_aresetn=0, asynchronously: state IDLE, all m00_axis_* outputs 0, s00_axis_tready 0, hdr_valid 0, hdr_* 0, drop_count 0, pending beat cleared.
REQ-025 Reset mid-frame SHALL discard the frame without tlast; the first beat after deassertion is treated as a new header.
REQ-026 s00_axis_tready SHALL rise on the first clock edge after deassertion.

Verification
REQ-027 Frame 64+64 bytes, dst=local, m00_axis_tready=1 -> two output beats: 50 bytes + 14 bytes and 50 bytes tail tkeep=2^50-1, tlast on 2nd; hdr_valid=1 once.
REQ-028 Single beat, tkeep=2^20-1, dst=broadcast -> one beat, tkeep=6'h3F, tlast=1; single beat, tkeep=2^14-1 -> no output, drop_count=1.
REQ-029 dst mismatch, promisc_in=0, 3-beat frame -> no output, tready=1 throughout, drop_count increments by 1; repeated with promisc_in=1 -> frame delivered.
REQ-030 Random m00_axis_tready (50%) over 100 frames, lengths 15-1500 -> byte stream equals input minus 14 header bytes, outputs stable while stalled.
REQ-031 Reset asserted during STREAM of a 4-beat frame -> all outputs 0 immediately; next frame parsed correctly.

Source files
------------

// File: rtl/ethernet_header_strip.sv
// rtl/ethernet_header_strip.sv - strip the 14-byte Ethernet header from an AXI-Stream frame
//
// Ports:
//   s00_axis_aclk / s00_axis_aresetn : clock, asynchronous active-low reset
//   s00_axis_*                       : upstream frame, Ethernet header in bytes 0-13 of beat 0
//   m00_axis_*                       : payload stream realigned so the first payload byte is byte 0
//   local_mac_addr_in / promisc_in   : destination filter (station MAC, accept-all)
//   hdr_valid / hdr_*                : parsed header fields, pulse on every first beat
//   drop_count                       : saturating count of discarded frames (filtered or runt)
module ethernet_header_strip #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_aresetn,
    input  logic                  s00_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s00_axis_tkeep,
    input  logic                  s00_axis_tlast,
    input  logic [1:0]            s00_axis_tuser,
    output logic                  s00_axis_tready,
    output logic                  m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m00_axis_tkeep,
    output logic                  m00_axis_tlast,
    output logic [1:0]            m00_axis_tuser,
    input  logic                  m00_axis_tready,
    input  logic [47:0]           local_mac_addr_in,
    input  logic                  promisc_in,
    output logic                  hdr_valid,
    output logic [47:0]           hdr_dst_mac,
    output logic [47:0]           hdr_src_mac,
    output logic [15:0]           hdr_eth_type,
    output logic [31:0]           drop_count
);

    localparam int HDR_BYTES = 14;
    localparam int HDR_BITS  = HDR_BYTES * 8;
    localparam int REM_BYTES = KEEP_WIDTH - HDR_BYTES;
    localparam int REM_BITS  = REM_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_TAIL   = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    live_q;
    logic [DATA_WIDTH-1:0]   pend_data_q, pend_data_d;
    logic [KEEP_WIDTH-1:0]   pend_keep_q, pend_keep_d;
    logic [1:0]              pend_user_q, pend_user_d;
    logic                    m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0]   m_keep_q, m_keep_d;
    logic                    m_last_q, m_last_d;
    logic [1:0]              m_user_q, m_user_d;
    logic                    hdr_valid_q, hdr_valid_d;
    logic [47:0]             dst_q, dst_d;
    logic [47:0]             src_q, src_d;
    logic [15:0]             type_q, type_d;
    logic [31:0]             drop_q, drop_d;

    logic                    out_free;
    logic                    s_ready;
    logic                    s_fire;
    logic [47:0]             in_dst;
    logic [47:0]             in_src;
    logic [15:0]             in_type;
    logic                    in_long;
    logic                    dst_match;
    logic [DATA_WIDTH-1:0]   in_mask;
    logic [DATA_WIDTH-1:0]   joined_data;
    logic [KEEP_WIDTH-1:0]   joined_keep;
    logic [31:0]             drop_inc;

    assign out_free = !m_valid_q || m00_axis_tready;

    // live_q holds tready low through reset and until the first edge after release.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_IDLE, ST_STREAM: s_ready = live_q && out_free;
            ST_DROP:            s_ready = live_q;
            default:            s_ready = 1'b0;
        endcase
    end

    assign s_fire = s00_axis_tvalid && s_ready;

    always_comb begin
        in_dst  = '0;
        in_src  = '0;
        in_mask = '0;
        for (int i = 0; i < 6; i++) begin
            in_dst[47-8*i -: 8] = s00_axis_tdata[8*i +: 8];
            in_src[47-8*i -: 8] = s00_axis_tdata[8*(i+6) +: 8];
        end
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            in_mask[8*i +: 8] = {8{s00_axis_tkeep[i]}};
        end
    end

    assign in_type   = {s00_axis_tdata[103:96], s00_axis_tdata[111:104]};
    // With contiguous tkeep, byte 14 valid means the beat holds more than 14 bytes.
    assign in_long   = s00_axis_tkeep[HDR_BYTES];
    assign dst_match = promisc_in || (in_dst == local_mac_addr_in) ||
                       (in_dst == 48'hFFFF_FFFF_FFFF);

    // Upper part of the pending beat followed by the first 14 bytes of the new beat.
    assign joined_data = (pend_data_q >> HDR_BITS) | (s00_axis_tdata << REM_BITS);
    assign joined_keep = (pend_keep_q >> HDR_BYTES) | (s00_axis_tkeep << REM_BYTES);
    assign drop_inc    = (drop_q == 32'hFFFF_FFFF) ? drop_q : drop_q + 32'd1;

    always_comb begin
        state_d     = state_q;
        pend_data_d = pend_data_q;
        pend_keep_d = pend_keep_q;
        pend_user_d = pend_user_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        m_user_d    = m_user_q;
        hdr_valid_d = 1'b0;
        dst_d       = dst_q;
        src_d       = src_q;
        type_d      = type_q;
        drop_d      = drop_q;

        if (m_valid_q && m00_axis_tready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_fire) begin
                    hdr_valid_d = 1'b1;
                    dst_d       = in_dst;
                    src_d       = in_src;
                    type_d      = in_type;
                    if (!s00_axis_tlast) begin
                        if (dst_match) begin
                            pend_data_d = s00_axis_tdata & in_mask;
                            pend_keep_d = s00_axis_tkeep;
                            pend_user_d = s00_axis_tuser;
                            state_d     = ST_STREAM;
                        end else begin
                            drop_d  = drop_inc;
                            state_d = ST_DROP;
                        end
                    end else if (dst_match && in_long) begin
                        m_valid_d = 1'b1;
                        m_data_d  = s00_axis_tdata >> HDR_BITS;
                        m_keep_d  = s00_axis_tkeep >> HDR_BYTES;
                        m_last_d  = 1'b1;
                        m_user_d  = s00_axis_tuser;
                    end else begin
                        // Rejected single-beat frame or runt with no payload.
                        drop_d = drop_inc;
                    end
                end
            end

            ST_STREAM: begin
                if (s_fire) begin
                    m_valid_d = 1'b1;
                    m_data_d  = joined_data;
                    m_keep_d  = joined_keep;
                    m_last_d  = s00_axis_tlast && !in_long;
                    m_user_d  = s00_axis_tuser;
                    if (!s00_axis_tlast || in_long) begin
                        // Masking here leaves the residue beat zero above its valid bytes.
                        pend_data_d = s00_axis_tdata & in_mask;
                        pend_keep_d = s00_axis_tkeep;
                        pend_user_d = s00_axis_tuser;
                    end
                    if (s00_axis_tlast) begin
                        state_d = in_long ? ST_TAIL : ST_IDLE;
                    end
                end
            end

            ST_TAIL: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = pend_data_q >> HDR_BITS;
                    m_keep_d  = pend_keep_q >> HDR_BYTES;
                    m_last_d  = 1'b1;
                    m_user_d  = pend_user_q;
                    state_d   = ST_IDLE;
                end
            end

            ST_DROP: begin
                if (s_fire && s00_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q     <= ST_IDLE;
            live_q      <= 1'b0;
            pend_data_q <= '0;
            pend_keep_q <= '0;
            pend_user_q <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_user_q    <= '0;
            hdr_valid_q <= 1'b0;
            dst_q       <= '0;
            src_q       <= '0;
            type_q      <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            live_q      <= 1'b1;
            pend_data_q <= pend_data_d;
            pend_keep_q <= pend_keep_d;
            pend_user_q <= pend_user_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
            m_user_q    <= m_user_d;
            hdr_valid_q <= hdr_valid_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            type_q      <= type_d;
            drop_q      <= drop_d;
        end
    end

    assign s00_axis_tready = s_ready;
    assign m00_axis_tvalid = m_valid_q;
    assign m00_axis_tdata  = m_data_q;
    assign m00_axis_tkeep  = m_keep_q;
    assign m00_axis_tlast  = m_last_q;
    assign m00_axis_tuser  = m_user_q;
    assign hdr_valid       = hdr_valid_q;
    assign hdr_dst_mac     = dst_q;
    assign hdr_src_mac     = src_q;
    assign hdr_eth_type    = type_q;
    assign drop_count      = drop_q;

endmodule

// File: tb/tb_ethernet_header_strip.sv
// tb/tb_ethernet_header_strip.sv - scoreboard bench for ethernet_header_strip
module tb_ethernet_header_strip;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [1:0]    user;
    } beat_t;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
    } hdr_t;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic [KW-1:0] s_keep;
    logic          s_last;
    logic [1:0]    s_user;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic          m_last;
    logic [1:0]    m_user;
    logic          m_ready;
    logic [47:0]   local_mac;
    logic          promisc;
    logic          hdr_valid;
    logic [47:0]   hdr_dst;
    logic [47:0]   hdr_src;
    logic [15:0]   hdr_type;
    logic [31:0]   drop_count;

    int    checks = 0;
    int    errors = 0;
    int    exp_drops = 0;
    bit    rand_en = 0;
    bit    gap_en = 0;
    beat_t exp_q[$];
    hdr_t  hdr_q[$];

    ethernet_header_strip #(.DATA_WIDTH(DW)) dut (
        .s00_axis_aclk     (clk),
        .s00_axis_aresetn  (rst_n),
        .s00_axis_tvalid   (s_valid),
        .s00_axis_tdata    (s_data),
        .s00_axis_tkeep    (s_keep),
        .s00_axis_tlast    (s_last),
        .s00_axis_tuser    (s_user),
        .s00_axis_tready   (s_ready),
        .m00_axis_tvalid   (m_valid),
        .m00_axis_tdata    (m_data),
        .m00_axis_tkeep    (m_keep),
        .m00_axis_tlast    (m_last),
        .m00_axis_tuser    (m_user),
        .m00_axis_tready   (m_ready),
        .local_mac_addr_in (local_mac),
        .promisc_in        (promisc),
        .hdr_valid         (hdr_valid),
        .hdr_dst_mac       (hdr_dst),
        .hdr_src_mac       (hdr_src),
        .hdr_eth_type      (hdr_type),
        .drop_count        (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        m_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [KW-1:0] keep_of(input int n);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < n; i++) k[i] = 1'b1;
        return k;
    endfunction

    function automatic logic [DW-1:0] mask_of(input logic [KW-1:0] k);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < KW; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and header pulse.
    logic          pv_stall = 1'b0;
    logic [DW-1:0] pv_data;
    logic [KW-1:0] pv_keep;
    logic          pv_last;
    logic [1:0]    pv_user;

    always @(negedge clk) begin
        beat_t e;
        hdr_t  h;
        if (!rst_n) begin
            pv_stall = 1'b0;
        end else begin
            if (pv_stall) begin
                checks++;
                if (!(m_valid === 1'b1 && m_data === pv_data && m_keep === pv_keep &&
                      m_last === pv_last && m_user === pv_user)) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%b keep=%h last=%b user=%h, expected held keep=%h last=%b user=%h",
                             m_valid, m_keep, m_last, m_user, pv_keep, pv_last, pv_user);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat: got unexpected beat keep=%h last=%b, expected none", m_keep, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (m_keep !== e.keep || m_last !== e.last || m_user !== e.user ||
                        (m_data & mask_of(e.keep)) !== e.data) begin
                        errors++;
                        $display("FAIL out_beat: got keep=%h last=%b user=%h data=%h, expected keep=%h last=%b user=%h data=%h",
                                 m_keep, m_last, m_user, m_data & mask_of(e.keep), e.keep, e.last, e.user, e.data);
                    end
                end
            end
            pv_stall = m_valid && !m_ready;
            pv_data  = m_data;
            pv_keep  = m_keep;
            pv_last  = m_last;
            pv_user  = m_user;
            if (hdr_valid) begin
                checks++;
                if (hdr_q.size() == 0) begin
                    errors++;
                    $display("FAIL hdr: got unexpected hdr_valid pulse, expected none");
                end else begin
                    h = hdr_q.pop_front();
                    if (hdr_dst !== h.dst || hdr_src !== h.src || hdr_type !== h.typ) begin
                        errors++;
                        $display("FAIL hdr: got %h/%h/%h expected %h/%h/%h",
                                 hdr_dst, hdr_src, hdr_type, h.dst, h.src, h.typ);
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input logic [1:0] u, output bit first_rdy);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_user  = u;
        n = 0;
        @(negedge clk);
        first_rdy = s_ready;
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("in_tready_timeout", DW'(s_ready), DW'(1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Reference model: payload is the frame minus 14 bytes, cut into KW-byte beats;
    // output beat k carries the tuser of input beat k+1 (capped at the last beat).
    task automatic send_frame(input int len, input logic [47:0] dst, input bit chk_drop_rdy,
                              input int abort_after);
        logic [7:0]    bb[];
        logic [1:0]    ub[];
        int            nb, nsend, off, k, n;
        bit            acc, rdy1;
        beat_t         e;
        hdr_t          h;
        logic [DW-1:0] d;
        nb = (len + KW - 1) / KW;
        bb = new[nb * KW];
        ub = new[nb];
        foreach (bb[i]) bb[i] = 8'($urandom);
        foreach (ub[i]) ub[i] = 2'($urandom);
        for (int i = 0; i < 6; i++) bb[i] = dst[47-8*i -: 8];
        for (int i = 0; i < 6; i++) begin
            h.dst[47-8*i -: 8] = bb[i];
            h.src[47-8*i -: 8] = bb[6+i];
        end
        h.typ = {bb[12], bb[13]};
        hdr_q.push_back(h);
        acc   = promisc || dst == local_mac || dst == BCAST;
        nsend = (abort_after > 0) ? abort_after : nb;
        if (!acc || len <= 14) begin
            exp_drops++;
        end else begin
            off = 14;
            k   = 0;
            while (off < len) begin
                n = (len - off < KW) ? len - off : KW;
                e.data = '0;
                for (int j = 0; j < n; j++) e.data[8*j +: 8] = bb[off+j];
                e.keep = keep_of(n);
                e.last = (off + n >= len);
                e.user = ub[(k + 1 < nb) ? k + 1 : nb - 1];
                if (abort_after == 0 || k < abort_after - 1) exp_q.push_back(e);
                off += n;
                k++;
            end
        end
        for (int b = 0; b < nsend; b++) begin
            n = (len - b * KW < KW) ? len - b * KW : KW;
            for (int j = 0; j < KW; j++) d[8*j +: 8] = bb[b*KW + j];
            send_beat(d, keep_of(n), (b == nb - 1), ub[b], rdy1);
            if (chk_drop_rdy && b > 0) chk("drop_tready", DW'(rdy1), DW'(1));
            if (gap_en && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", DW'(exp_q.size() + hdr_q.size()), DW'(0));
        exp_q.delete();
        hdr_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_m_tvalid", DW'(m_valid), DW'(0));
        chk("rst_m_tdata", m_data, DW'(0));
        chk("rst_m_tkeep_last_user", DW'({m_keep, m_last, m_user}), DW'(0));
        chk("rst_s_tready", DW'(s_ready), DW'(0));
        chk("rst_hdr", DW'({hdr_valid, hdr_dst, hdr_src, hdr_type}), DW'(0));
        chk("rst_drop_count", DW'(drop_count), DW'(0));
    endtask

    function automatic logic [47:0] other_mac();
        logic [47:0] m;
        m = {16'($urandom), 32'($urandom)};
        m[47:40] = 8'h0A;
        if (m == local_mac) m[0] = ~m[0];
        return m;
    endfunction

    initial begin
        int lens[9];
        rst_n     = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        s_keep    = '0;
        s_last    = 1'b0;
        s_user    = '0;
        m_ready   = 1'b1;
        promisc   = 1'b0;
        local_mac = 48'h0200_5E10_2030;
        #1 rst_n = 1'b0;
        #2;
        chk_reset_outputs();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("tready_before_edge", DW'(s_ready), DW'(0));
        @(posedge clk);
        #1 chk("tready_after_edge", DW'(s_ready), DW'(1));

        send_frame(128, local_mac, 0, 0);
        wait_drain();
        chk("drops_two_beat", DW'(drop_count), DW'(exp_drops));

        send_frame(20, BCAST, 0, 0);
        send_frame(14, local_mac, 0, 0);
        wait_drain();
        chk("drops_runt", DW'(drop_count), DW'(exp_drops));

        send_frame(150, other_mac(), 1, 0);
        wait_drain();
        chk("drops_mismatch", DW'(drop_count), DW'(exp_drops));
        promisc = 1'b1;
        send_frame(150, other_mac(), 0, 0);
        wait_drain();
        promisc = 1'b0;
        chk("drops_promisc", DW'(drop_count), DW'(exp_drops));

        lens = '{64, 65, 78, 79, 127, 128, 129, 142, 143};
        foreach (lens[i]) send_frame(lens[i], local_mac, 0, 0);
        wait_drain();

        rand_en = 1'b1;
        gap_en  = 1'b1;
        for (int f = 0; f < 100; f++) begin
            int          len, sel;
            logic [47:0] d;
            len = $urandom_range(15, 1500);
            sel = $urandom_range(0, 3);
            d = (sel < 2) ? local_mac : (sel == 2) ? BCAST : other_mac();
            promisc = ($urandom_range(0, 7) == 0);
            send_frame(len, d, 0, 0);
        end
        promisc = 1'b0;
        wait_drain();
        chk("drops_random", DW'(drop_count), DW'(exp_drops));
        rand_en = 1'b0;
        gap_en  = 1'b0;
        wait_drain();

        send_frame(256, local_mac, 0, 3);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        chk("sb_empty_at_reset", DW'(exp_q.size() + hdr_q.size()), DW'(0));
        exp_q.delete();
        hdr_q.delete();
        exp_drops = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("tready_before_edge2", DW'(s_ready), DW'(0));
        @(posedge clk);
        #1 chk("tready_after_edge2", DW'(s_ready), DW'(1));
        send_frame(200, local_mac, 0, 0);
        wait_drain();
        chk("drops_after_reset", DW'(drop_count), DW'(exp_drops));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
